// File: rtl/mul_in_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_in_arb_pkg
//  Purpose  : Shared types and helpers for the multi-requester PIO read
//             arbiter: FSM state encoding and round-robin pointer advance.
//  Revision : 1.0  initial release
// ============================================================================
package mul_in_arb_pkg;

    // Largest supported requester count and the pointer width that covers it
    localparam int MAX_REQ   = 8;
    localparam int PTR_MAX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    // Advance a round-robin pointer, wrapping at num_req so that codes above
    // num_req-1 are never produced for non-power-of-two requester counts.
    function automatic logic [PTR_MAX_W-1:0] next_ptr(
        input logic [PTR_MAX_W-1:0] ptr,
        input int                   num_req
    );
        if (int'(ptr) >= num_req - 1) begin
            return '0;
        end
        return ptr + 3'd1;
    endfunction

endpackage : mul_in_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin priority picker. Searches the request
//             vector upward from ptr with wrap-around and returns the first
//             asserted requester as a one-hot vector and a binary index.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               any_req
);

    int   w_cand;
    logic w_found;

    assign any_req = |req;

    // Walk NUM_REQ slots starting at ptr; first asserted request wins
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        w_found    = 1'b0;
        w_cand     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = int'(ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!w_found && req[w_cand]) begin
                w_found            = 1'b1;
                winner[w_cand]     = 1'b1;
                winner_idx         = PTR_W'(w_cand);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mul_in_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mul_in_read_arbiter
//  Purpose  : Round-robin arbiter sharing one Avalon-MM input-PIO read slave
//             (registered readdata, 1-cycle read latency) among NUM_REQ
//             requesters. One read per three cycles under continuous load.
//  Revision : 1.0  initial release
// ============================================================================
module mul_in_read_arbiter
    import mul_in_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         slv_address,
    input  logic [DATA_W-1:0]         slv_readdata,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_q,       state_d;
    logic [PTR_W-1:0]    ptr_q,         ptr_d;
    logic [PTR_W-1:0]    owner_q,       owner_d;
    logic [NUM_REQ-1:0]  gnt_q,         gnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q,    rsp_data_d;
    logic [ADDR_W-1:0]   slv_address_q, slv_address_d;
    logic                busy_q,        busy_d;

    logic [PTR_W-1:0]    w_next_owner;
    logic [PTR_W-1:0]    w_arb_ptr;
    logic [NUM_REQ-1:0]  w_winner;
    logic [PTR_W-1:0]    w_win_idx;
    logic                w_any_req;
    logic [ADDR_W-1:0]   w_win_addr;
    logic                w_arb_en;

    // Pointer value that takes effect once the current owner has been served
    assign w_next_owner = PTR_W'(next_ptr(PTR_MAX_W'(owner_q), NUM_REQ));

    // In RESP the pointer is being advanced this same cycle, so arbitrate with
    // the advanced value to keep the rotation strict under continuous load.
    assign w_arb_ptr = (state_q == RESP) ? w_next_owner : ptr_q;

    rr_pick #(
        .NUM_REQ    (NUM_REQ),
        .PTR_W      (PTR_W)
    ) u_rr_pick (
        .req        (req),
        .ptr        (w_arb_ptr),
        .winner     (w_winner),
        .winner_idx (w_win_idx),
        .any_req    (w_any_req)
    );

    assign w_win_addr = req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];

    // Next-state and registered-output computation for the read sequencer
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        gnt_d         = '0;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        slv_address_d = slv_address_q;
        w_arb_en      = 1'b0;

        case (state_q)
            IDLE: begin
                w_arb_en = 1'b1;
            end
            ADDR: begin
                state_d = DATA;
            end
            DATA: begin
                rsp_data_d           = slv_readdata;
                rsp_valid_d[owner_q] = 1'b1;
                state_d              = RESP;
            end
            RESP: begin
                ptr_d    = w_next_owner;
                w_arb_en = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared arbitration step for IDLE and RESP; address frozen here
        if (w_arb_en && w_any_req) begin
            gnt_d         = w_winner;
            owner_d       = w_win_idx;
            slv_address_d = w_win_addr;
            state_d       = ADDR;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            slv_address_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            gnt_q         <= gnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            slv_address_q <= slv_address_d;
            busy_q        <= busy_d;
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign slv_address = slv_address_q;
    assign busy        = busy_q;

endmodule : mul_in_read_arbiter
`default_nettype wire

// File: tb/tb_mul_in_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_in_read_arbiter
//  Purpose  : Self-checking bench for mul_in_read_arbiter. A transaction-level
//             reference model predicts grants, responses, busy and address
//             per cycle; directed scenarios are followed by random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_in_read_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int AW   = 2;
    localparam int MAXC = 4000;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [AW-1:0]     slv_address;
    logic [DW-1:0]     slv_readdata;
    logic              busy;
    logic [DW-1:0]     in_port;

    // Reference-model expectations, indexed by cycle number
    logic [N-1:0]      exp_gnt     [MAXC];
    logic [N-1:0]      exp_rsp     [MAXC];
    bit                exp_busy    [MAXC];
    bit                addr_set    [MAXC];
    logic [AW-1:0]     addr_val    [MAXC];
    logic [AW-1:0]     rd_addr     [MAXC];
    bit                rst_hit     [MAXC];
    logic [DW-1:0]     inport_hist [MAXC];

    int                cyc;
    int                next_arb;
    int                m_ptr;
    logic [AW-1:0]     m_addr;
    int                n_cmp;
    int                n_bad;
    bit                chk_en;

    always #5 clk = ~clk;

    mul_in_read_arbiter #(
        .NUM_REQ      (N),
        .DATA_W       (DW),
        .ADDR_W       (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_addr     (req_addr),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .slv_address  (slv_address),
        .slv_readdata (slv_readdata),
        .busy         (busy)
    );

    // Input PIO: only address 0 maps the input port, readdata registered
    initial slv_readdata = '0;
    always @(posedge clk) slv_readdata <= (slv_address == '0) ? in_port : '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Transaction-level prediction for the inputs driven in cycle cyc
    task automatic model();
        int w;
        int idx;
        logic [AW-1:0] a;
        if (reset) begin
            m_ptr    = 0;
            next_arb = cyc + 1;
            for (int k = 1; k <= 3; k++) begin
                exp_gnt[cyc+k]  = '0;
                exp_rsp[cyc+k]  = '0;
                exp_busy[cyc+k] = 1'b0;
                addr_set[cyc+k] = 1'b0;
            end
            rst_hit[cyc+1] = 1'b1;
        end else if (cyc >= next_arb && req != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && req[idx]) w = idx;
            end
            a = req_addr[w*AW +: AW];
            exp_gnt[cyc+1][w] = 1'b1;
            exp_rsp[cyc+3][w] = 1'b1;
            for (int k = 1; k <= 3; k++) exp_busy[cyc+k] = 1'b1;
            addr_set[cyc+1] = 1'b1;
            addr_val[cyc+1] = a;
            rd_addr[cyc+3]  = a;
            m_ptr    = (w + 1) % N;
            next_arb = cyc + 3;
        end
    endtask

    task automatic check_outputs();
        logic [DW-1:0] ed;
        if (rst_hit[cyc]) m_addr = '0;
        else if (addr_set[cyc]) m_addr = addr_val[cyc];
        chk("gnt",         32'(gnt),         32'(exp_gnt[cyc]));
        chk("rsp_valid",   32'(rsp_valid),   32'(exp_rsp[cyc]));
        chk("busy",        32'(busy),        32'(exp_busy[cyc]));
        chk("slv_address", 32'(slv_address), 32'(m_addr));
        if (exp_rsp[cyc] != '0) begin
            ed = (rd_addr[cyc] == '0) ? inport_hist[cyc-2] : '0;
            chk("rsp_data", rsp_data, ed);
        end else if (rst_hit[cyc]) begin
            chk("rsp_data_rst", rsp_data, '0);
        end
    endtask

    // One clock cycle: drive inputs after the edge, predict, check mid-cycle
    task automatic step(input logic r, input logic [N-1:0] rq,
                        input logic [N*AW-1:0] ad, input logic [DW-1:0] ip);
        @(posedge clk);
        #1;
        reset    = r;
        req      = rq;
        req_addr = ad;
        in_port  = ip;
        inport_hist[cyc] = ip;
        model();
        @(negedge clk);
        if (chk_en) check_outputs();
        chk_en = 1'b1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic [DW-1:0] ip);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, ip);
    endtask

    initial begin
        logic [N-1:0]    rq;
        logic [N*AW-1:0] ad;
        for (int k = 0; k < MAXC; k++) begin
            exp_gnt[k] = '0; exp_rsp[k] = '0; exp_busy[k] = 1'b0;
            addr_set[k] = 1'b0; addr_val[k] = '0; rd_addr[k] = '0;
            rst_hit[k] = 1'b0; inport_hist[k] = '0;
        end
        cyc = 0; next_arb = 0; m_ptr = 0; m_addr = '0;
        n_cmp = 0; n_bad = 0; chk_en = 1'b0;
        reset = 1'b1; req = '0; req_addr = '0; in_port = '0;

        step(1'b1, '0, '0, '0);
        step(1'b1, '0, '0, '0);

        // Single request from requester 0, address 0
        step(1'b0, 4'b0001, '0, 32'hDEADBEEF);
        step(1'b0, 4'b0001, '0, 32'hDEADBEEF);
        idle(5, 32'hDEADBEEF);

        // All four requesting continuously: rotation 0,1,2,3,0
        step(1'b1, '0, '0, 32'hCAFE0001);
        for (int k = 0; k < 16; k++) step(1'b0, 4'b1111, 8'h00, 32'hCAFE0000 + 32'(k));
        idle(5, 32'h0);

        // Non-zero address reads zero from the PIO
        step(1'b0, 4'b0001, 8'h01, 32'h12345678);
        step(1'b0, 4'b0001, 8'h01, 32'h12345678);
        idle(4, 32'h12345678);

        // Address changes after grant must not affect the read in flight
        step(1'b0, 4'b0001, 8'h00, 32'hA5A5_5A5A);
        step(1'b0, 4'b0001, 8'h03, 32'hA5A5_5A5A);
        idle(4, 32'hA5A5_5A5A);

        // Reset during DATA discards the response; requester 3 then served
        step(1'b0, 4'b0010, 8'h00, 32'h11111111);
        step(1'b0, 4'b0010, 8'h00, 32'h11111111);
        step(1'b1, 4'b0000, 8'h00, 32'h11111111);
        idle(2, 32'h22222222);
        step(1'b0, 4'b1000, 8'h00, 32'h33333333);
        step(1'b0, 4'b1000, 8'h00, 32'h33333333);
        idle(4, 32'h33333333);

        // Request from requester 2 withdrawn before any arbitration slot
        step(1'b0, 4'b0001, 8'h00, 32'h44444444);
        step(1'b0, 4'b0101, 8'h00, 32'h44444444);
        idle(20, 32'h44444444);

        // Random traffic with requesters mostly following the handshake
        rq = '0;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) begin
                if (rq[i]) begin
                    if (exp_gnt[cyc-1][i]) begin
                        if ($urandom_range(3) != 0) rq[i] = 1'b0;
                    end else if ($urandom_range(15) == 0) begin
                        rq[i] = 1'b0;
                    end
                end else if ($urandom_range(3) == 0) begin
                    rq[i] = 1'b1;
                end
            end
            ad = N*AW'($urandom);
            step(($urandom_range(199) == 0), rq, ad, $urandom);
        end
        idle(6, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mul_in_read_arbiter
`default_nettype wire
